// File: rtl/fertilising_scheduler_if.sv
// Operator/sensor inputs and actuator/status outputs of the fertilising scheduler.
interface fertilising_scheduler_if #(
  parameter int unsigned CNT_W = 8
);
  logic             fertilise_push;
  logic             splinker;
  logic             critical_level;
  logic             empty_tank;
  logic             fertilising;
  logic             cleaning;
  logic             alarm;
  logic             busy;
  logic [CNT_W-1:0] dose_count;

  // Operator / environment side
  modport master (
    output fertilise_push, splinker, critical_level, empty_tank,
    input  fertilising, cleaning, alarm, busy, dose_count
  );

  // Scheduler side
  modport slave (
    input  fertilise_push, splinker, critical_level, empty_tank,
    output fertilising, cleaning, alarm, busy, dose_count
  );
endinterface

// File: rtl/fertilising_scheduler.sv
// Fertilisation cycle sequencer: WAIT for sprinkler, DOSE, CLEAN, with latched ALARM.
module fertilising_scheduler #(
  parameter int unsigned WAIT_TICKS  = 16,
  parameter int unsigned DOSE_TICKS  = 8,
  parameter int unsigned CLEAN_TICKS = 4,
  parameter int unsigned CNT_W       = 8
) (
  input logic                   clock,
  input logic                   reset,
  fertilising_scheduler_if.slave bus
);

  localparam int unsigned MAX_WD    = (WAIT_TICKS > DOSE_TICKS) ? WAIT_TICKS : DOSE_TICKS;
  localparam int unsigned MAX_TICKS = (MAX_WD > CLEAN_TICKS) ? MAX_WD : CLEAN_TICKS;
  localparam int unsigned TW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

  // Encoding chosen so each output is a single state flop:
  // bit0 = busy, bit1 = valve, bit2 = pump, bit3 = alarm.
  typedef enum logic [3:0] {
    IDLE  = 4'b0000,
    WAIT  = 4'b0001,
    DOSE  = 4'b0011,
    CLEAN = 4'b0101,
    ALARM = 4'b1000
  } state_t;

  state_t           state;
  logic [TW-1:0]    timer;
  logic [CNT_W-1:0] count;
  logic             push_q;
  logic             primed;
  logic             alarm_pending;
  logic             push_rise;

  // Operator request edge; suppressed on the first cycle out of reset so a held button is ignored.
  assign push_rise = bus.fertilise_push & ~push_q & primed;

  // Sequencer: state, shared down-counter, pending-alarm flag and dose counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      timer         <= '0;
      count         <= '0;
      push_q        <= 1'b0;
      primed        <= 1'b0;
      alarm_pending <= 1'b0;
    end else begin
      push_q <= bus.fertilise_push;
      primed <= 1'b1;
      case (state)
        IDLE: begin
          if (push_rise) begin
            if (bus.critical_level) begin
              state <= ALARM;
            end else begin
              state <= WAIT;
              timer <= TW'(WAIT_TICKS - 1);
            end
          end
        end
        WAIT: begin
          if (bus.critical_level) begin
            state <= ALARM;
          end else if (bus.splinker) begin
            state <= DOSE;
            timer <= TW'(DOSE_TICKS - 1);
          end else if (timer == '0) begin
            state <= ALARM;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        DOSE: begin
          if (bus.critical_level) begin
            state <= CLEAN;
            timer <= TW'(CLEAN_TICKS - 1);
          end else if (!bus.splinker) begin
            state         <= CLEAN;
            timer         <= TW'(CLEAN_TICKS - 1);
            alarm_pending <= 1'b1;
          end else if (timer == '0) begin
            state <= CLEAN;
            timer <= TW'(CLEAN_TICKS - 1);
            if (count != '1) count <= count + 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        CLEAN: begin
          if (timer == '0 || bus.empty_tank) begin
            state         <= alarm_pending ? ALARM : IDLE;
            alarm_pending <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ALARM: begin
          if (push_rise && !bus.critical_level) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs straight from state flops; pump additionally gated by an empty tank.
  assign bus.busy        = state[0];
  assign bus.fertilising = state[1];
  assign bus.cleaning    = state[2] & ~bus.empty_tank;
  assign bus.alarm       = state[3];
  assign bus.dose_count  = count;

endmodule

// File: tb/tb_fertilising_scheduler.sv
// Self-checking bench: directed scenario table, hand sequences, randomized run vs reference model.
module tb_fertilising_scheduler;

  localparam int unsigned WT = 16;
  localparam int unsigned DT = 8;
  localparam int unsigned CT = 4;
  localparam int unsigned CW = 2;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  fertilising_scheduler_if #(.CNT_W(CW)) bus ();

  fertilising_scheduler #(
    .WAIT_TICKS(WT), .DOSE_TICKS(DT), .CLEAN_TICKS(CT), .CNT_W(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- reference model (phase + elapsed cycles in phase) ----------------
  localparam int P_IDLE = 0, P_WAIT = 1, P_DOSE = 2, P_CLEAN = 3, P_ALARM = 4;
  int m_ph, m_el, m_cnt;
  bit m_pend, m_pq, m_pr;

  function automatic void m_reset();
    m_ph = P_IDLE; m_el = 0; m_cnt = 0; m_pend = 0; m_pq = 0; m_pr = 0;
  endfunction

  // Advance one clock using the inputs the DUT will sample at the coming edge.
  function automatic void m_step();
    bit rise;
    bit crit;
    rise = bus.fertilise_push && !m_pq && m_pr;
    crit = bus.critical_level;
    m_pq = bus.fertilise_push;
    m_pr = 1;
    case (m_ph)
      P_IDLE:  if (rise) begin m_ph = crit ? P_ALARM : P_WAIT; m_el = 0; end
      P_WAIT: begin
        if (crit) m_ph = P_ALARM;
        else if (bus.splinker) begin m_ph = P_DOSE; m_el = 0; end
        else if (m_el == WT - 1) m_ph = P_ALARM;
        else m_el++;
      end
      P_DOSE: begin
        if (crit) begin m_ph = P_CLEAN; m_el = 0; end
        else if (!bus.splinker) begin m_ph = P_CLEAN; m_el = 0; m_pend = 1; end
        else if (m_el == DT - 1) begin
          m_ph = P_CLEAN; m_el = 0;
          m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
        end else m_el++;
      end
      P_CLEAN: begin
        if (m_el == CT - 1 || bus.empty_tank) begin
          m_ph = m_pend ? P_ALARM : P_IDLE; m_pend = 0;
        end else m_el++;
      end
      default: if (rise && !crit) m_ph = P_IDLE;
    endcase
  endfunction

  function automatic int m_out();
    return {26'd0, m_ph == P_DOSE, (m_ph == P_CLEAN) && !bus.empty_tank, m_ph == P_ALARM,
            (m_ph >= P_WAIT) && (m_ph <= P_CLEAN), 2'(m_cnt)};
  endfunction

  function automatic int dut_out();
    return {26'd0, bus.fertilising, bus.cleaning, bus.alarm, bus.busy, bus.dose_count};
  endfunction

  // Async reset pulse between clock edges.
  task automatic pulse_reset();
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    m_reset();
  endtask

  // ---------------- directed scenario table ----------------
  typedef struct {
    string name;
    bit    spl;
    bit    crit_pre;
    int    crit_at;
    int    drop_at;
    int    empty_at;
    int    e_fert;
    int    e_clean;
    int    e_busy;
    bit    e_alarm;
    int    e_inc;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int exp_cnt;
    int nf, nc, nb;
    bit hit;
    errors = 0;
    checks = 0;

    tbl[0] = '{"nominal",    1'b1, 1'b0, -1, -1, -1, 8, 4, 13, 1'b0, 1};
    tbl[1] = '{"no_sprink",  1'b0, 1'b0, -1, -1, -1, 0, 0, 16, 1'b1, 0};
    tbl[2] = '{"crit_dose",  1'b1, 1'b0,  3, -1, -1, 3, 4,  8, 1'b0, 0};
    tbl[3] = '{"drop_dose",  1'b1, 1'b0, -1,  5, -1, 5, 4, 10, 1'b1, 0};
    tbl[4] = '{"empty_cln",  1'b1, 1'b0, -1, -1,  2, 8, 2, 11, 1'b0, 1};
    tbl[5] = '{"crit_idle",  1'b1, 1'b1, -1, -1, -1, 0, 0,  0, 1'b1, 0};

    reset = 1'b1;
    bus.fertilise_push = 1'b0;
    bus.splinker       = 1'b0;
    bus.critical_level = 1'b0;
    bus.empty_tank     = 1'b0;
    #12;
    chk("reset_outputs", dut_out(), 0);
    reset = 1'b0;
    tick();
    chk("idle_after_reset", dut_out(), 0);

    exp_cnt = 0;
    for (int v = 0; v < 6; v++) begin
      bus.splinker       = tbl[v].spl;
      bus.critical_level = tbl[v].crit_pre;
      bus.fertilise_push = 1'b1;
      nf = 0; nc = 0; nb = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
        tick();
        if (bus.fertilising) nf++;
        if (bus.cleaning)    nc++;
        if (bus.busy)        nb++;
        if (tbl[v].crit_at >= 0 && nf == tbl[v].crit_at) bus.critical_level = 1'b1;
        if (tbl[v].drop_at >= 0 && nf == tbl[v].drop_at) bus.splinker = 1'b0;
        if (tbl[v].empty_at >= 0 && nc == tbl[v].empty_at && bus.cleaning && !bus.empty_tank) begin
          bus.empty_tank = 1'b1;
          #1;
          chk({tbl[v].name, "_pump_off_now"}, 32'(bus.cleaning), 0);
        end
      end
      exp_cnt = (exp_cnt + tbl[v].e_inc > CNT_MAX) ? CNT_MAX : exp_cnt + tbl[v].e_inc;
      chk({tbl[v].name, "_fert_cycles"},  nf, tbl[v].e_fert);
      chk({tbl[v].name, "_clean_cycles"}, nc, tbl[v].e_clean);
      chk({tbl[v].name, "_busy_cycles"},  nb, tbl[v].e_busy);
      chk({tbl[v].name, "_alarm"},        32'(bus.alarm), 32'(tbl[v].e_alarm));
      chk({tbl[v].name, "_dose_count"},   32'(bus.dose_count), exp_cnt);
      bus.empty_tank     = 1'b0;
      bus.fertilise_push = 1'b0;
      bus.critical_level = 1'b0;
      tick();
      if (tbl[v].e_alarm) begin
        bus.critical_level = 1'b1;
        bus.fertilise_push = 1'b1;
        tick();
        chk({tbl[v].name, "_alarm_hold_crit"}, 32'(bus.alarm), 1);
        bus.fertilise_push = 1'b0;
        bus.critical_level = 1'b0;
        tick();
        bus.fertilise_push = 1'b1;
        tick();
        chk({tbl[v].name, "_alarm_clear"}, {bus.alarm, bus.busy}, 0);
        bus.fertilise_push = 1'b0;
        tick();
      end
    end

    // Async reset mid-DOSE, with the button still held through reset.
    bus.splinker       = 1'b1;
    bus.fertilise_push = 1'b1;
    nf = 0;
    hit = 1'b0;
    for (int cyc = 0; cyc < 20 && !hit; cyc++) begin
      tick();
      if (bus.fertilising) nf++;
      if (nf == 3) hit = 1'b1;
    end
    chk("reach_dose_cycle3", 32'(hit), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_outputs", dut_out(), 0);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("held_push_no_rise", 32'(bus.busy), 0);
    bus.fertilise_push = 1'b0;
    tick();
    bus.fertilise_push = 1'b1;
    tick();
    chk("push_after_release", 32'(bus.busy), 1);
    bus.fertilise_push = 1'b0;
    for (int i = 0; i < 16; i++) tick();

    // Counter saturation from zero: five nominal doses.
    pulse_reset();
    tick();
    for (int d = 0; d < 5; d++) begin
      bus.fertilise_push = 1'b1;
      for (int i = 0; i < 16; i++) tick();
      bus.fertilise_push = 1'b0;
      tick();
    end
    chk("count_saturate", 32'(bus.dose_count), CNT_MAX);
    chk("saturate_no_alarm", 32'(bus.alarm), 0);

    // Randomized run against the reference model.
    bus.fertilise_push = 1'b0;
    bus.critical_level = 1'b0;
    bus.empty_tank     = 1'b0;
    pulse_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 3) == 0) bus.fertilise_push = ~bus.fertilise_push;
      bus.splinker       = ($urandom_range(0, 9) != 0);
      bus.critical_level = ($urandom_range(0, 24) == 0);
      bus.empty_tank     = ($urandom_range(0, 14) == 0);
      m_step();
      tick();
      chk($sformatf("random_cyc%0d", cyc), dut_out(), m_out());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
